// File: rtl/dct_pkg.sv
// Shared constants and coefficient types for the DCT transpose stage.
// Ports: none (package).
package dct_pkg;
  localparam int N     = 4;   // transform size
  localparam int IN_W  = 36;  // incoming row coefficient width
  localparam int OUT_W = 16;  // stored / outgoing coefficient width
  localparam int SHIFT = 3;   // first-stage rounding shift
  localparam int IDX_W = $clog2(N);

  typedef logic signed [IN_W-1:0]  coef_in_t;
  typedef logic signed [OUT_W-1:0] coef_out_t;

  localparam coef_out_t OUT_MAX = coef_out_t'(16'sh7FFF);
  localparam coef_out_t OUT_MIN = coef_out_t'(16'sh8000);
endpackage

// File: rtl/dct_transpose_buf_if.sv
// Row-in / column-out handshake bundle of the transpose buffer.
// slave  : transpose buffer view (accepts rows, presents columns).
// master : producer/consumer view (drives rows, accepts columns).
interface dct_transpose_buf_if;
  import dct_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [N*IN_W-1:0]      in_row;       // element c at [c*IN_W +: IN_W]
  logic                   out_valid;
  logic                   out_ready;
  logic [N*OUT_W-1:0]     out_col;      // row r at [r*OUT_W +: OUT_W]
  logic [IDX_W-1:0]       out_col_idx;
  logic                   out_last;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_col_idx, out_last
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_col_idx, out_last
  );
endinterface

// File: rtl/dct_transpose_buf_round_sat.sv
// dct_round_sat: combinational round-to-nearest right shift by SHIFT followed
// by saturation to the OUT_W signed range, for one coefficient.
// Ports: coef_i (signed IN_W in), coef_o (signed OUT_W out).
module dct_round_sat
  import dct_pkg::*;
(
  input  coef_in_t  coef_i,
  output coef_out_t coef_o
);

  // One extra bit of headroom so adding the rounding offset to the most
  // positive input cannot wrap.
  function automatic coef_out_t round_sat(input coef_in_t x);
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    rnd          = '0;
    rnd[SHIFT-1] = 1'b1;
    sum          = {x[IN_W-1], x} + rnd;
    shifted      = sum >>> SHIFT;
    if (shifted > (IN_W+1)'(OUT_MAX))
      return OUT_MAX;
    else if (shifted < (IN_W+1)'(OUT_MIN))
      return OUT_MIN;
    else
      return coef_out_t'(shifted[OUT_W-1:0]);
  endfunction

  assign coef_o = round_sat(coef_i);

endmodule

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: collects N rounded/saturated rows of a block into one of
// two ping-pong banks, then presents that bank column by column. One bank
// fills while the other drains, so one row in and one column out per cycle
// are sustained.
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (slave view of dct_transpose_buf_if: row handshake in,
//             column handshake out with column index and last flag).
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  dct_transpose_buf_if.slave   bus
);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_col_q, rd_col_d;

  coef_out_t        mem_q [2][N][N];   // [bank][row][col]
  coef_out_t        coef_sat [N];

  logic             wr_fire;
  logic             rd_valid;
  logic             rd_fire;

  // Write path: per-element round/saturate ahead of storage.
  for (genvar c = 0; c < N; c++) begin : g_rs
    dct_round_sat u_rs (
      .coef_i (coef_in_t'(bus.in_row[c*IN_W +: IN_W])),
      .coef_o (coef_sat[c])
    );
  end

  assign bus.in_ready = !full_q[wr_bank_q];
  assign wr_fire      = bus.in_valid && !full_q[wr_bank_q];
  assign rd_valid     = full_q[rd_bank_q];
  assign rd_fire      = rd_valid && bus.out_ready;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;

    if (wr_fire) begin
      wr_row_d = wr_row_q + 1'b1;
      if (wr_row_q == IDX_W'(N-1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_row_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // A write only targets an empty bank and a drain only a full one, so the
    // two updates of full_d never hit the same bit.
    if (rd_fire) begin
      rd_col_d = rd_col_q + 1'b1;
      if (rd_col_q == IDX_W'(N-1)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_col_d          = '0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Storage carries no reset; full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < N; c++)
        mem_q[wr_bank_q][wr_row_q][c] <= coef_sat[c];
    end
  end

  // Read path: the selected column gathers element rd_col of every row.
  for (genvar r = 0; r < N; r++) begin : g_col
    assign bus.out_col[r*OUT_W +: OUT_W] = mem_q[rd_bank_q][r][rd_col_q];
  end

  assign bus.out_valid   = rd_valid;
  assign bus.out_col_idx = rd_col_q;
  assign bus.out_last    = rd_valid && (rd_col_q == IDX_W'(N-1));

endmodule
